// File: rtl/arb_pkg.sv
// Shared types for the round-robin arbiter.
package arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/pry2oht.sv
// Priority-to-one-hot converter: keeps only the lowest-index set bit of the input.
module pry2oht #(
    parameter int unsigned WIDTH          = 4,
    parameter int unsigned SPLIT          = 2,
    parameter int unsigned IMPLEMENTATION = 0
) (
    input  logic [WIDTH-1:0] pry,
    output logic [WIDTH-1:0] oht,
    output logic             vld
);

    assign vld = |pry;

    if (IMPLEMENTATION == 0) begin : g_loop
        logic found;

        always_comb begin
            oht   = '0;
            found = 1'b0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (pry[i] && !found) begin
                    oht[i] = 1'b1;
                    found  = 1'b1;
                end
            end
        end

    end else if (IMPLEMENTATION == 1) begin : g_vector
        // Two-level tree: groups of SPLIT bits, each bit blocked by any lower
        // group or any lower bit inside its own group.
        localparam int unsigned NGRP = (WIDTH + SPLIT - 1) / SPLIT;
        localparam int unsigned PAD  = NGRP * SPLIT - WIDTH;

        logic [NGRP*SPLIT-1:0] pry_pad;
        logic [NGRP-1:0]       grp_any;

        if (PAD > 0) begin : g_pad
            assign pry_pad = {{PAD{1'b0}}, pry};
        end else begin : g_nopad
            assign pry_pad = pry;
        end

        for (genvar g = 0; g < int'(NGRP); g++) begin : g_grp
            assign grp_any[g] = |pry_pad[g*SPLIT +: SPLIT];
        end

        for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
            localparam int unsigned GI = i / SPLIT;
            localparam int unsigned OI = i % SPLIT;
            if (GI == 0 && OI == 0) begin : g_first
                assign oht[i] = pry[i];
            end else if (OI == 0) begin : g_grp_head
                assign oht[i] = pry[i] & ~(|grp_any[GI-1:0]);
            end else if (GI == 0) begin : g_grp0
                assign oht[i] = pry[i] & ~(|pry[i-1:0]);
            end else begin : g_inner
                assign oht[i] = pry[i] & ~(|grp_any[GI-1:0]) & ~(|pry[i-1:i-OI]);
            end
        end

        logic unused_pad;
        assign unused_pad = ^pry_pad;

    end else begin : g_adder
        // Two's-complement trick: x & -x isolates the lowest set bit.
        localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
        assign oht = pry & (~pry + ONE);
    end

endmodule

// File: rtl/rr_arbiter.sv
// Registered round-robin arbiter; grants are held across multi-beat transfers
// closed by a last beat, and the rotating mask advances only at transfer end.
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned WIDTH          = 4,
    parameter int unsigned SPLIT          = 2,
    parameter int unsigned IMPLEMENTATION = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         req,
    input  logic                     ack,
    input  logic                     lst,
    output logic [WIDTH-1:0]         gnt,
    output logic                     vld,
    output logic [$clog2(WIDTH)-1:0] idx
);

    localparam int unsigned IW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    arb_state_t       state;
    logic [WIDTH-1:0] msk;
    logic [WIDTH-1:0] msk_nxt;
    logic [WIDTH-1:0] msk_use;
    logic [WIDTH-1:0] req_msk;
    logic [WIDTH-1:0] oht_msk;
    logic [WIDTH-1:0] oht_all;
    logic [WIDTH-1:0] win;
    logic [IW-1:0]    win_idx;
    logic             vld_msk;
    logic             vld_all;
    logic             xfer_end;

    assign xfer_end = (state == BUSY) && ack && lst;

    // Bits strictly above the granted one: ~((gnt << 1) - 1). Empty for the top index.
    assign msk_nxt = ~((gnt << 1) - ONE);
    assign msk_use = xfer_end ? msk_nxt : msk;
    assign req_msk = req & msk_use;

    pry2oht #(
        .WIDTH          (WIDTH),
        .SPLIT          (SPLIT),
        .IMPLEMENTATION (IMPLEMENTATION)
    ) u_pry_msk (
        .pry (req_msk),
        .oht (oht_msk),
        .vld (vld_msk)
    );

    pry2oht #(
        .WIDTH          (WIDTH),
        .SPLIT          (SPLIT),
        .IMPLEMENTATION (IMPLEMENTATION)
    ) u_pry_all (
        .pry (req),
        .oht (oht_all),
        .vld (vld_all)
    );

    // Unmasked fallback wraps priority back to the lowest-index requester.
    assign win = vld_msk ? oht_msk : oht_all;

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (win[i]) begin
                win_idx = win_idx | IW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            msk   <= '1;
            gnt   <= '0;
            vld   <= 1'b0;
            idx   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (vld_all) begin
                        state <= BUSY;
                        gnt   <= win;
                        vld   <= 1'b1;
                        idx   <= win_idx;
                    end
                end
                BUSY: begin
                    if (xfer_end) begin
                        msk <= msk_nxt;
                        if (vld_all) begin
                            gnt <= win;
                            idx <= win_idx;
                        end else begin
                            state <= IDLE;
                            gnt   <= '0;
                            vld   <= 1'b0;
                            idx   <= '0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed table-driven bench: six arbiters (three implementations, widths 4 and 9)
// share one stimulus stream and are all checked against hand-computed grants.
module tb_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [8:0] req9;
    logic       ack;
    logic       lst;

    logic [2:0][3:0] gnt4;
    logic [2:0]      vld4;
    logic [2:0][1:0] idx4;
    logic [2:0][8:0] gnt9;
    logic [2:0]      vld9;
    logic [2:0][3:0] idx9;

    int tests;
    int fails;

    assign req9 = {5'b0, req};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        rr_arbiter #(
            .WIDTH          (4),
            .SPLIT          (2),
            .IMPLEMENTATION (g)
        ) u_w4 (
            .clk   (clk),
            .rst_n (rst_n),
            .req   (req),
            .ack   (ack),
            .lst   (lst),
            .gnt   (gnt4[g]),
            .vld   (vld4[g]),
            .idx   (idx4[g])
        );

        rr_arbiter #(
            .WIDTH          (9),
            .SPLIT          (3),
            .IMPLEMENTATION (g)
        ) u_w9 (
            .clk   (clk),
            .rst_n (rst_n),
            .req   (req9),
            .ack   (ack),
            .lst   (lst),
            .gnt   (gnt9[g]),
            .vld   (vld9[g]),
            .idx   (idx9[g])
        );
    end

    // The granted requester must keep req up until its last beat.
    always @(negedge clk) begin
        if (rst_n && vld4[0] && !(ack && lst)) begin
            assert (req[idx4[0]])
            else $error("protocol: granted requester %0d dropped req", idx4[0]);
        end
    end

    typedef struct {
        string      name;
        logic [3:0] req;
        logic       ack;
        logic       lst;
        logic [3:0] gnt;
        logic       vld;
        int         idx;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input logic [3:0] r, input logic a, input logic l,
                       input logic [3:0] eg, input logic ev, input int ei);
        vec_t v;
        v.name = name;
        v.req  = r;
        v.ack  = a;
        v.lst  = l;
        v.gnt  = eg;
        v.vld  = ev;
        v.idx  = ei;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [3:0] eg, input logic ev, input int ei);
        logic [8:0] eg9;
        logic [1:0] ei4;
        logic [3:0] ei9;
        eg9 = {5'b0, eg};
        ei4 = 2'(ei);
        ei9 = 4'(ei);
        for (int d = 0; d < 3; d++) begin
            tests++;
            if (gnt4[d] !== eg || vld4[d] !== ev || idx4[d] !== ei4) begin
                fails++;
                $display("FAIL %s w4 impl%0d: got gnt=%b vld=%b idx=%0d, want gnt=%b vld=%b idx=%0d",
                         name, d, gnt4[d], vld4[d], idx4[d], eg, ev, ei);
            end
            tests++;
            if (gnt9[d] !== eg9 || vld9[d] !== ev || idx9[d] !== ei9) begin
                fails++;
                $display("FAIL %s w9 impl%0d: got gnt=%b vld=%b idx=%0d, want gnt=%b vld=%b idx=%0d",
                         name, d, gnt9[d], vld9[d], idx9[d], eg9, ev, ei);
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;

        //  name            req      ack   lst   gnt      vld   idx
        add("first_grant",  4'b1111, 1'b0, 1'b0, 4'b0001, 1'b1, 0);
        add("rot_1",        4'b1111, 1'b1, 1'b1, 4'b0010, 1'b1, 1);
        add("rot_2",        4'b1111, 1'b1, 1'b1, 4'b0100, 1'b1, 2);
        add("rot_3",        4'b1111, 1'b1, 1'b1, 4'b1000, 1'b1, 3);
        add("rot_wrap",     4'b1111, 1'b1, 1'b1, 4'b0001, 1'b1, 0);
        add("hold_noack",   4'b1111, 1'b0, 1'b0, 4'b0001, 1'b1, 0);
        add("lock_beat1",   4'b0101, 1'b1, 1'b0, 4'b0001, 1'b1, 0);
        add("lock_beat2",   4'b0101, 1'b1, 1'b0, 4'b0001, 1'b1, 0);
        add("lock_beat3",   4'b0101, 1'b1, 1'b0, 4'b0001, 1'b1, 0);
        add("lock_last",    4'b0101, 1'b1, 1'b1, 4'b0100, 1'b1, 2);
        add("to_idx3",      4'b1000, 1'b1, 1'b1, 4'b1000, 1'b1, 3);
        add("idx3_hold",    4'b1000, 1'b0, 1'b0, 4'b1000, 1'b1, 3);
        add("wrap_fallbk",  4'b1001, 1'b1, 1'b1, 4'b0001, 1'b1, 0);
        add("sole_1",       4'b0010, 1'b1, 1'b1, 4'b0010, 1'b1, 1);
        add("sole_2",       4'b0010, 1'b1, 1'b1, 4'b0010, 1'b1, 1);
        add("sole_3",       4'b0010, 1'b1, 1'b1, 4'b0010, 1'b1, 1);
        add("to_idle",      4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 0);
        add("idle_acklst",  4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 0);
        add("idle_req",     4'b0100, 1'b0, 1'b0, 4'b0100, 1'b1, 2);
        add("sole_idx2",    4'b0100, 1'b1, 1'b1, 4'b0100, 1'b1, 2);
        add("to_idle_2",    4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 0);
        add("idle_fallbk",  4'b0011, 1'b0, 1'b0, 4'b0001, 1'b1, 0);
        add("pre_rst_1",    4'b0010, 1'b1, 1'b1, 4'b0010, 1'b1, 1);
        add("pre_rst_2",    4'b0100, 1'b1, 1'b1, 4'b0100, 1'b1, 2);
        add("pre_rst_hold", 4'b0110, 1'b0, 1'b0, 4'b0100, 1'b1, 2);

        rst_n = 1'b0;
        req   = 4'b1111;
        ack   = 1'b0;
        lst   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", 4'b0000, 1'b0, 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            req = vecs[i].req;
            ack = vecs[i].ack;
            lst = vecs[i].lst;
            @(posedge clk);
            #1;
            check(vecs[i].name, vecs[i].gnt, vecs[i].vld, vecs[i].idx);
        end

        // Asynchronous reset mid-transfer: outputs clear without a clock edge,
        // and the mask returns to all ones, so 0110 grants index 1, not 2.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 4'b0000, 1'b0, 0);
        rst_n = 1'b1;
        req   = 4'b0110;
        ack   = 1'b0;
        lst   = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset", 4'b0010, 1'b1, 1);
        ack = 1'b1;
        lst = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_rot", 4'b0100, 1'b1, 2);
        ack = 1'b0;
        lst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
